// File: rtl/hazard_scoreboard_unit_if.sv
// hazard_scoreboard_unit_if: pipeline-register and scoreboard signals between the datapath and the hazard unit
interface hazard_scoreboard_unit_if #(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32
);
    localparam int ADDR_W = $clog2(NUM_REGS);
    localparam int OUT_W  = $clog2(MAX_OUTSTANDING + 1);
    logic [ADDR_W-1:0]   Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd;
    logic                RegWriteD, LongOpD, BranchD, RegWriteE, ResultSrcE, PCSrcE;
    logic                RegWriteM, ResultSrcM, RegWriteW, LongDoneValid;
    logic [1:0]          ForwardAE, ForwardBE;
    logic                ForwardAD, ForwardBD, StallF, StallD, FlushD, FlushE;
    logic [NUM_REGS-1:0] PendingMask;
    logic [OUT_W-1:0]    Outstanding;
    logic [CNT_W-1:0]    StallCount, FlushCount;
    modport master (
        output Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd,
               RegWriteD, LongOpD, BranchD, RegWriteE, ResultSrcE, PCSrcE,
               RegWriteM, ResultSrcM, RegWriteW, LongDoneValid,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushD, FlushE,
               PendingMask, Outstanding, StallCount, FlushCount
    );
    modport slave (
        input  Rs1D, Rs2D, RdD, Rs1E, Rs2E, RdE, RdM, RdW, LongDoneRd,
               RegWriteD, LongOpD, BranchD, RegWriteE, ResultSrcE, PCSrcE,
               RegWriteM, ResultSrcM, RegWriteW, LongDoneValid,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushD, FlushE,
               PendingMask, Outstanding, StallCount, FlushCount
    );
endinterface

// File: rtl/hazard_scoreboard_unit.sv
// hazard_scoreboard_unit: forwarding, stall/flush control, long-op scoreboard and saturating event counters
module hazard_scoreboard_unit #(
    parameter int NUM_REGS        = 32,
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_W           = 32
) (
    input logic clk,
    input logic rst,
    hazard_scoreboard_unit_if.slave hz
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] OUT_ONE = OUT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic [OUT_W-1:0]    out_q, out_d;
    logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    logic lwstall, branchstall, sbstall, fullstall, stall, stall_f, flush_e, done, issue, inc, dec;

    always_comb begin
        hz.ForwardAE = (hz.RegWriteM && hz.Rs1E != '0 && hz.RdM == hz.Rs1E) ? 2'b10 :
                       (hz.RegWriteW && hz.Rs1E != '0 && hz.RdW == hz.Rs1E) ? 2'b01 : 2'b00;
        hz.ForwardBE = (hz.RegWriteM && hz.Rs2E != '0 && hz.RdM == hz.Rs2E) ? 2'b10 :
                       (hz.RegWriteW && hz.Rs2E != '0 && hz.RdW == hz.Rs2E) ? 2'b01 : 2'b00;
        hz.ForwardAD = hz.RegWriteM && hz.Rs1D != '0 && hz.RdM == hz.Rs1D;
        hz.ForwardBD = hz.RegWriteM && hz.Rs2D != '0 && hz.RdM == hz.Rs2D;
    end

    // x0 is never marked pending, so the scoreboard terms need no explicit x0 guard
    always_comb begin
        done        = hz.LongDoneValid && hz.LongDoneRd != '0 && pend_q[hz.LongDoneRd];
        lwstall     = hz.RegWriteE && hz.ResultSrcE && hz.RdE != '0 &&
                      (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        branchstall = hz.BranchD &&
                      ((hz.RegWriteE && hz.RdE != '0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D)) ||
                       (hz.ResultSrcM && hz.RdM != '0 && (hz.RdM == hz.Rs1D || hz.RdM == hz.Rs2D)));
        sbstall     = pend_q[hz.Rs1D] || pend_q[hz.Rs2D] || (hz.RegWriteD && pend_q[hz.RdD]);
        fullstall   = hz.LongOpD && hz.RegWriteD && out_q == OUT_MAX && !done;
        stall       = lwstall || branchstall || sbstall || fullstall;
        stall_f     = stall && !hz.PCSrcE;
        flush_e     = stall || hz.PCSrcE;
        issue       = hz.RegWriteD && hz.LongOpD && hz.RdD != '0 && !stall && !hz.PCSrcE;
    end

    assign hz.StallF = stall_f;
    assign hz.StallD = stall_f;
    assign hz.FlushD = hz.PCSrcE;
    assign hz.FlushE = flush_e;

    // clear first so a same-register issue wins over the completion
    always_comb begin
        pend_d = pend_q;
        if (done) pend_d[hz.LongDoneRd] = 1'b0;
        if (issue) pend_d[hz.RdD] = 1'b1;
        dec         = done && out_q != '0;
        inc         = issue && (out_q != OUT_MAX || dec);
        out_d       = (inc && !dec) ? out_q + OUT_ONE : (dec && !inc) ? out_q - OUT_ONE : out_q;
        stall_cnt_d = (stall_f && !(&stall_cnt_q)) ? stall_cnt_q + CNT_ONE : stall_cnt_q;
        flush_cnt_d = ((hz.PCSrcE || flush_e) && !(&flush_cnt_q)) ? flush_cnt_q + CNT_ONE : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q      <= '0;
            out_q       <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pend_q      <= pend_d;
            out_q       <= out_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz.PendingMask = pend_q;
    assign hz.Outstanding = out_q;
    assign hz.StallCount  = stall_cnt_q;
    assign hz.FlushCount  = flush_cnt_q;
endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Next-generation hazard unit for the 5-stage RISC-V pipeline.
- Keeps the combinational forwarding and stall logic (E-stage forwarding from M/W, D-stage branch operand forwarding from M, load-use and branch stalls).
- Adds a registered scoreboard for variable-latency write-back ops (MUL/DIV, slow memory), a bounded outstanding-op counter, taken-branch flush generation and saturating stall/flush performance counters.
- Sits beside the datapath; drives the F/D/E pipeline-register enables and clears.

Parameters:
NUM_REGS, 32, architectural registers; register index width ADDR_W = clog2(NUM_REGS)
MAX_OUTSTANDING, 4, maximum in-flight long ops (>=1)
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
Rs1D, Rs2D, RdD  in  ADDR_W  decode-stage source and destination registers
RegWriteD  in  1  decode instruction writes Rd
LongOpD  in  1  decode instruction is a variable-latency op
BranchD  in  1  decode instruction is a branch
Rs1E, Rs2E, RdE  in  ADDR_W  execute-stage registers
RegWriteE, ResultSrcE  in  1  execute writes Rd / execute is a load
PCSrcE  in  1  taken branch/jump resolved in E
RdM  in  ADDR_W; RegWriteM, ResultSrcM  in  1  memory stage
RdW  in  ADDR_W; RegWriteW  in  1  write-back stage
LongDoneValid  in  1  a long op completes this cycle
LongDoneRd  in  ADDR_W  destination of the completing long op
ForwardAE, ForwardBE  out  2  00 regfile, 01 from W, 10 from M
ForwardAD, ForwardBD  out  1  forward M result to D branch comparator
StallF, StallD  out  1  hold PC and IF/ID registers
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register (insert bubble)
PendingMask  out  NUM_REGS  scoreboard state
Outstanding  out  clog2(MAX_OUTSTANDING+1)  in-flight long-op count
StallCount, FlushCount  out  CNT_W  saturating event counters

Behaviour:
- Reset (async, rst=1): PendingMask=0, Outstanding=0, StallCount=0, FlushCount=0. Combinational outputs follow their equations; with all-zero inputs every output is 0.
- Register x0 is never forwarded, never pending, and never causes a stall.
- ForwardAE/BE:
  - 10 if RegWriteM and RdM==RsxE!=0.
  - Else 01 if RegWriteW and RdW==RsxE!=0.
  - Else 00. M has priority over W.
- ForwardAD/BD: RegWriteM and RdM==RsxD!=0.
- lwstall: RegWriteE & ResultSrcE & RdE!=0 & (RdE==Rs1D | RdE==Rs2D). Only a true dependency stalls.
- branchstall: BranchD & one of:
  - RegWriteE & RdE!=0 & RdE matches Rs1D/Rs2D; or
  - ResultSrcM & RdM!=0 & RdM matches Rs1D/Rs2D.
- sbstall: PendingMask[Rs1D] | PendingMask[Rs2D] (RAW), or RegWriteD & PendingMask[RdD] (WAW), evaluated on the registered mask.
- fullstall: LongOpD & RegWriteD & Outstanding==MAX_OUTSTANDING & no completion this cycle.
- stall = lwstall | branchstall | sbstall | fullstall.
- StallF = StallD = stall & ~PCSrcE.
- FlushE = stall | PCSrcE.
- FlushD = PCSrcE. A taken branch overrides stalls; the stalled decode instruction is on the wrong path.
- Issue event: RegWriteD & LongOpD & RdD!=0 & ~stall & ~PCSrcE.
- Scoreboard update at clk edge:
  - Issue sets PendingMask[RdD].
  - LongDoneValid clears PendingMask[LongDoneRd].
  - If issue and completion hit the same register, set wins.
  - LongDoneValid for a non-pending register or x0 is ignored and does not decrement Outstanding.
- Outstanding update:
  - +1 on issue; -1 on a valid completion; unchanged when both happen.
  - Never exceeds MAX_OUTSTANDING and never underflows.
- Completion forwarding: none. Decode reads the regfile the cycle after the clear (write-first regfile), so the stall deasserts one cycle after LongDoneValid.
- StallCount: +1 each cycle StallF=1. FlushCount: +1 each cycle FlushD|FlushE=1. Both saturate at all-ones.
- Reset asserted mid-operation clears the scoreboard and counters immediately. In-flight long ops are the datapath's responsibility.

Test Plan:
- Forwarding priority: RegWriteM=RegWriteW=1, RdM=RdW=Rs1E=5 -> ForwardAE=10. Set RegWriteM=0 -> ForwardAE=01. Set Rs1E=0 -> ForwardAE=00.
- Load-use: RegWriteE=ResultSrcE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1, FlushD=0. Change Rs2D=8 -> all 0. StallCount increments exactly once.
- Scoreboard RAW: issue long op RdD=10, then hold Rs1D=10 -> stall each cycle until LongDoneValid with LongDoneRd=10. Stall drops the following cycle. PendingMask returns to 0; Outstanding goes 0->1->0.
- Capacity: MAX_OUTSTANDING=2, issue long ops to x3 and x4, then a third to x5 -> fullstall. Completing x3 in the same cycle -> x5 issues, Outstanding stays 2.
- Taken branch during stall: sbstall active and PCSrcE=1 -> StallF=0, FlushD=FlushE=1, no issue. FlushCount +1.
- Async reset: assert rst between clock edges with PendingMask!=0 -> PendingMask, Outstanding and both counters read 0 before the next clk edge.
